// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave: sequencer state encoding,
// protocol widths and the R/W bit polarity.
package i2c_pkg;

    localparam int   I2C_DW      = 8;
    localparam int   I2C_ADDR_W  = 7;
    localparam logic I2C_RW_READ = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_seq_state_t;

endpackage

// File: rtl/i2c_slave_seq.sv
// I2C slave bit/byte sequencer. Consumes filtered SCL/SDA levels and their
// edge pulses, detects START/STOP, matches the 7-bit address, shifts write
// bytes in (valid/ready handoff) and read bytes out (tx_load request), and
// drives the ACK bit through the open-drain enable sda_oe.
// Optional build macro I2C_GENCALL_EN: also ACK the general-call address
// 7'h00 with R/W=0 and expose the gencall flag.
module i2c_slave_seq
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h42,
    parameter int                    DW         = I2C_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl_f,
    input  logic          sda_f,
    input  logic          scl_pe,
    input  logic          scl_ne,
    input  logic          sda_pe,
    input  logic          sda_ne,
    output logic          sda_oe,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    input  logic [DW-1:0] tx_data,
    output logic          tx_load,
    output logic          start_det,
    output logic          stop_det,
    output logic          busy
`ifdef I2C_GENCALL_EN
    ,
    output logic          gencall
`endif
);

    localparam logic [2:0] IDLE      = 3'(ST_IDLE);
    localparam logic [2:0] ADDR      = 3'(ST_ADDR);
    localparam logic [2:0] ADDR_ACK  = 3'(ST_ADDR_ACK);
    localparam logic [2:0] WR_DATA   = 3'(ST_WR_DATA);
    localparam logic [2:0] WR_ACK    = 3'(ST_WR_ACK);
    localparam logic [2:0] RD_DATA   = 3'(ST_RD_DATA);
    localparam logic [2:0] RD_ACK    = 3'(ST_RD_ACK);
    localparam logic [2:0] WAIT_STOP = 3'(ST_WAIT_STOP);

    logic [2:0]            state;
    logic [3:0]            bit_cnt;
    logic [DW-1:0]         sr;
    logic                  rw;
    logic                  overflow;
    logic                  master_nack;

    logic                  start_cond;
    logic                  stop_cond;
    logic                  bus_cond;
    logic [I2C_ADDR_W-1:0] addr_field;
    logic                  own_hit;
    logic                  gc_hit;
    logic                  addr_ack;
    logic [DW-1:0]         sr_shift;
    logic                  byte_done;

    // Bus conditions: SDA moving while SCL is high.
    assign start_cond = sda_ne & scl_f;
    assign stop_cond  = sda_pe & scl_f;
    assign bus_cond   = start_cond | stop_cond;

    assign addr_field = sr[DW-1:1];
    assign own_hit    = (addr_field == SLAVE_ADDR);
`ifdef I2C_GENCALL_EN
    // General call is a broadcast write only; a general-call read is NACKed.
    assign gc_hit     = (addr_field == '0) && (sr[0] != I2C_RW_READ);
`else
    assign gc_hit     = 1'b0;
`endif
    assign addr_ack   = own_hit | gc_hit;

    assign sr_shift   = {sr[DW-2:0], sda_f};

    // The eighth data bit of a write byte is being sampled this cycle.
    assign byte_done  = ~bus_cond & (state == WR_DATA) & scl_pe & (bit_cnt == 4'd7);

    // Sequencer: bus conditions first, then per-state SCL edge actions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            sr          <= '0;
            rw          <= 1'b0;
            overflow    <= 1'b0;
            master_nack <= 1'b0;
            sda_oe      <= 1'b0;
            tx_load     <= 1'b0;
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            tx_load   <= 1'b0;
            start_det <= start_cond;
            stop_det  <= stop_cond;
            if (start_cond) begin
                state    <= ADDR;
                bit_cnt  <= 4'd0;
                sda_oe   <= 1'b0;
                overflow <= 1'b0;
                busy     <= 1'b1;
            end else if (stop_cond) begin
                state    <= IDLE;
                sda_oe   <= 1'b0;
                overflow <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_pe && bit_cnt < 4'd8) begin
                            sr      <= sr_shift;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_ne && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            rw      <= sr[0];
                            if (addr_ack) begin
                                sda_oe <= 1'b1;
                                state  <= ADDR_ACK;
                            end else begin
                                state  <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_ne) begin
                            bit_cnt <= 4'd0;
                            if (rw == I2C_RW_READ) begin
                                sr      <= tx_data;
                                tx_load <= 1'b1;
                                sda_oe  <= ~tx_data[DW-1];
                                state   <= RD_DATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                state   <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_pe && bit_cnt < 4'd8) begin
                            sr      <= sr_shift;
                            bit_cnt <= bit_cnt + 4'd1;
                            // A byte still waiting for the consumer makes this one overflow.
                            if (byte_done && rx_valid) begin
                                overflow <= 1'b1;
                            end
                        end else if (scl_ne && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            sda_oe  <= ~overflow;
                            state   <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_ne) begin
                            sda_oe   <= 1'b0;
                            overflow <= 1'b0;
                            bit_cnt  <= 4'd0;
                            state    <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (scl_pe && bit_cnt < 4'd8) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_ne && bit_cnt == 4'd8) begin
                            // Release SDA so the master can ACK/NACK.
                            sda_oe      <= 1'b0;
                            bit_cnt     <= 4'd0;
                            master_nack <= 1'b1;
                            state       <= RD_ACK;
                        end else if (scl_ne && bit_cnt != 4'd0) begin
                            sr     <= {sr[DW-2:0], 1'b0};
                            sda_oe <= ~sr[DW-2];
                        end
                    end
                    RD_ACK: begin
                        if (scl_pe) begin
                            master_nack <= sda_f;
                        end else if (scl_ne) begin
                            if (!master_nack) begin
                                sr      <= tx_data;
                                tx_load <= 1'b1;
                                sda_oe  <= ~tx_data[DW-1];
                                bit_cnt <= 4'd0;
                                state   <= RD_DATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                state   <= WAIT_STOP;
                            end
                        end
                    end
                    WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end
                    IDLE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        sda_oe <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

    // Write-byte handoff: hold rx_data/rx_valid until the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (byte_done && !rx_valid) begin
            rx_data  <= sr_shift;
            rx_valid <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef I2C_GENCALL_EN
    // General-call flag: set with the general-call ACK, cleared by any bus condition.
    always_ff @(posedge clk) begin
        if (reset) begin
            gencall <= 1'b0;
        end else if (bus_cond) begin
            gencall <= 1'b0;
        end else if (state == ADDR && scl_ne && bit_cnt == 4'd8 && gc_hit) begin
            gencall <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/i2c_slave_seq.md
Name: i2c_slave_seq

Overview:
- Bit/byte sequencer for the I2C slave.
- Consumes the filtered SCL/SDA levels and their one-cycle edge pulses from the line filters.
- Detects START/STOP, matches the 7-bit address, shifts write bytes in and read bytes out, and drives the ACK bit.
- Sits between the line filters and the slave register file; hands bytes over through a valid/ready pair.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit device address compared against the first byte after START.
- DW, 8, byte width; fixed by protocol, exposed only for the shared package.

Ports:
- clk  in  1  system clock; SCL/SDA are oversampled by it.
- reset  in  1  synchronous, active-high.
- scl_f  in  1  filtered SCL level.
- sda_f  in  1  filtered SDA level.
- scl_pe  in  1  one-cycle pulse, filtered SCL rising edge.
- scl_ne  in  1  one-cycle pulse, filtered SCL falling edge.
- sda_pe  in  1  one-cycle pulse, filtered SDA rising edge.
- sda_ne  in  1  one-cycle pulse, filtered SDA falling edge.
- sda_oe  out  1  1 = pull SDA low (open-drain enable).
- rx_data  out  8  last written byte.
- rx_valid  out  1  rx_data valid; held until accepted.
- rx_ready  in  1  consumer accepts rx_data when rx_valid&rx_ready.
- tx_data  in  8  byte to send on a read; sampled when tx_load pulses.
- tx_load  out  1  one-cycle pulse: tx_data captured, supply the next byte.
- start_det  out  1  one-cycle pulse on START or repeated START.
- stop_det  out  1  one-cycle pulse on STOP.
- busy  out  1  high from START to STOP.

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; bit_cnt 0; shift register 0.
  - Reset mid-transfer releases SDA the same cycle it is registered.
- Bus conditions, evaluated every cycle in any state:
  - START = sda_ne & scl_f: state→ADDR, bit_cnt←0, sda_oe←0, start_det=1, busy←1.
  - STOP = sda_pe & scl_f: state→IDLE, sda_oe←0, stop_det=1, busy←0.
  - Either condition overrides any SCL-edge action in the same cycle.
- Timing rules: data is sampled on scl_pe; sda_oe changes only on scl_ne (or on START/STOP/reset).
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- ADDR:
  - scl_pe shifts sda_f in MSB-first and increments bit_cnt.
  - On the scl_ne after bit 8, compare sr[7:1] with SLAVE_ADDR:
    - match → sda_oe←1, ADDR_ACK;
    - mismatch → WAIT_STOP.
- ADDR_ACK, on the next scl_ne:
  - R/W=0 → sda_oe←0, bit_cnt←0, WR_DATA.
  - R/W=1 → capture tx_data, tx_load=1, sda_oe←~tx_data[7], RD_DATA.
- WR_DATA:
  - 8 bits shifted on scl_pe.
  - On the scl_pe of bit 8: if rx_valid=0, rx_data←byte and rx_valid←1; otherwise mark overflow (byte discarded).
  - On the following scl_ne: sda_oe←~overflow, go to WR_ACK.
- WR_ACK, on scl_ne: sda_oe←0, clear overflow, bit_cnt←0, WR_DATA.
- rx_valid handshake: cleared on the cycle after rx_valid&rx_ready. The handshake is independent of the bus; a STOP does not clear it.
- RD_DATA:
  - Each scl_ne after bits 1..7 drives the next bit (sda_oe←~bit).
  - The scl_ne after bit 8 sets sda_oe←0 (release for the master's ACK), then RD_ACK.
- RD_ACK:
  - On scl_pe, latch sda_f as master_nack.
  - On scl_ne: if master_nack=0, load the next tx byte (tx_load=1), drive its MSB, RD_DATA; otherwise WAIT_STOP.
- WAIT_STOP: SDA released; exits only on STOP, START or reset.
- Bit counter: 4-bit; wraps to 0 at each ACK phase; never exceeds 8.
- Latency:
  - rx_valid rises 1 clk after the scl_pe of bit 8.
  - sda_oe changes 1 clk after the scl_ne pulse.

Optional Feature:
- Macro I2C_GENCALL_EN.
- Defined:
  - address 7'h00 with R/W=0 is also ACKed and followed by WR_DATA;
  - extra output gencall (1 bit) is high from that ACK until STOP/START.
  - Address 7'h00 with R/W=1 is NACKed.
- Undefined: 7'h00 is treated as a mismatch; port gencall is absent.

Decomposition:
- Package i2c_pkg holds:
  - state enum i2c_seq_state_t (8 states, 3-bit encoding);
  - constants I2C_DW=8, I2C_ADDR_W=7, I2C_RW_READ=1'b1.
- Sub-module i2c_line_filter (shift-register glitch filter plus edge pulses) is instantiated twice at the top wrapper, for SCL and SDA, not inside this block.
- i2c_slave_seq itself stays a single module.

Test Plan:
- Write: START, addr 0x42+W, byte 0xA5, STOP, rx_ready=1 → ACK on both bytes; rx_data=0xA5, rx_valid pulses 1 clk; start_det and stop_det each pulse once.
- Mismatch: START, addr 0x43+W, byte 0x11 → sda_oe stays 0 throughout; rx_valid never asserts; state WAIT_STOP until STOP.
- Read: START, 0x42+R, tx_data 0x3C then 0xC3, master ACKs the first byte and NACKs the second → SDA carries 0x3C then 0xC3; tx_load pulses twice; SDA released after the NACK.
- Overflow: write 0x01, 0x02 with rx_ready=0 → first byte ACKed, second NACKed; rx_data stays 0x01.
- Repeated START mid-read after bit 4 → start_det pulse, sda_oe←0 the same cycle, state ADDR; the next address byte is accepted normally.
- Reset asserted during a read ACK phase with sda_oe=1 → sda_oe=0, busy=0 and all outputs 0 one clk after reset.
